// File: rtl/core_pkg.sv
// Shared decode/issue definitions: RV32 base opcodes, ID-stage FSM states and
// per-opcode register-usage helpers.
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HAZ   = 2'd1,
    S_RDY   = 2'd2
  } id_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_BRANCH, OP_STORE, OP_REG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Source operand blocked by an in-flight write in the given scoreboard.
  function automatic logic src_hazard(input logic [31:0] insn, input logic [31:0] pend);
    return (uses_rs1(insn[6:0]) & pend[insn[19:15]]) |
           (uses_rs2(insn[6:0]) & pend[insn[24:20]]);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Fetch / execute / writeback / redirect signal bundle around the ID issue stage.
interface id_issue_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              if_valid_i;
  logic              if_ready_o;
  logic [AWIDTH-1:0] if_pc_i;
  logic [DWIDTH-1:0] if_insn_i;
  logic              ex_valid_o;
  logic              ex_ready_i;
  logic [AWIDTH-1:0] ex_pc_o;
  logic [DWIDTH-1:0] ex_insn_o;
  logic [DWIDTH-1:0] ex_imm_o;
  logic [4:0]        ex_rd_o;
  logic [4:0]        ex_rs1_o;
  logic [4:0]        ex_rs2_o;
  logic [6:0]        ex_opcode_o;
  logic [2:0]        ex_funct3_o;
  logic [6:0]        ex_funct7_o;
  logic              wb_valid_i;
  logic [4:0]        wb_rd_i;
  logic              flush_i;
  logic [15:0]       stall_cnt_o;

  // slave: the issue controller; master: the surrounding pipeline
  modport slave (
    input  if_valid_i, if_pc_i, if_insn_i, ex_ready_i, wb_valid_i, wb_rd_i, flush_i,
    output if_ready_o, ex_valid_o, ex_pc_o, ex_insn_o, ex_imm_o, ex_rd_o, ex_rs1_o,
           ex_rs2_o, ex_opcode_o, ex_funct3_o, ex_funct7_o, stall_cnt_o
  );

  modport master (
    output if_valid_i, if_pc_i, if_insn_i, ex_ready_i, wb_valid_i, wb_rd_i, flush_i,
    input  if_ready_o, ex_valid_o, ex_pc_o, ex_insn_o, ex_imm_o, ex_rd_o, ex_rs1_o,
           ex_rs2_o, ex_opcode_o, ex_funct3_o, ex_funct7_o, stall_cnt_o
  );
endinterface

// File: rtl/id_issue_ctrl_decode.sv
// Single-stage RV32 field decode: splits the instruction and builds the
// sign-extended immediate for its format.
module decode
  import core_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o
);
  logic [31:0] imm32;

  assign pc_o     = pc_i;
  assign insn_o   = insn_i;
  assign opcode_o = insn_i[6:0];
  assign rd_o     = insn_i[11:7];
  assign funct3_o = insn_i[14:12];
  assign rs1_o    = insn_i[19:15];
  assign rs2_o    = insn_i[24:20];
  assign funct7_o = insn_i[31:25];

  always_comb begin
    case (insn_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
      OP_STORE:                 imm32 = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      OP_BRANCH:                imm32 = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                                         insn_i[30:25], insn_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {insn_i[31:12], 12'h000};
      OP_JAL:                   imm32 = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                                         insn_i[20], insn_i[30:21], 1'b0};
      default:                  imm32 = 32'h0;
    endcase
  end

  assign imm_o = DWIDTH'($signed(imm32));
endmodule

// File: rtl/id_issue_ctrl.sv
// ID pipeline register with RAW scoreboard: holds one fetched instruction and
// issues it once its sources are not pending and execute is ready.
module id_issue_ctrl
  import core_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  id_issue_ctrl_if.slave bus
);
  id_state_e         state_q, state_d;
  logic [AWIDTH-1:0] id_pc_q;
  logic [DWIDTH-1:0] id_insn_q;
  logic [31:0]       pend_q, pend_d, pend_clr, set_mask;
  logic [15:0]       stall_cnt_q;
  logic              id_valid, hazard, ex_valid, issue, if_ready, load;
  logic [6:0]        opcode;
  logic [4:0]        rd;

  decode #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_decode (
    .pc_i     (id_pc_q),
    .insn_i   (id_insn_q),
    .pc_o     (bus.ex_pc_o),
    .insn_o   (bus.ex_insn_o),
    .imm_o    (bus.ex_imm_o),
    .rd_o     (rd),
    .rs1_o    (bus.ex_rs1_o),
    .rs2_o    (bus.ex_rs2_o),
    .opcode_o (opcode),
    .funct3_o (bus.ex_funct3_o),
    .funct7_o (bus.ex_funct7_o)
  );

  assign bus.ex_rd_o     = rd;
  assign bus.ex_opcode_o = opcode;
  assign bus.ex_valid_o  = ex_valid;
  assign bus.if_ready_o  = if_ready;
  assign bus.stall_cnt_o = stall_cnt_q;

  // Writeback clear is applied before the hazard check so a retiring source
  // unblocks its consumer in the same cycle.
  always_comb begin
    pend_clr = pend_q;
    if (bus.wb_valid_i) pend_clr[bus.wb_rd_i] = 1'b0;
  end

  // FSM output process
  always_comb begin
    id_valid = (state_q != S_EMPTY);
    hazard   = src_hazard(id_insn_q[31:0], pend_clr);
    ex_valid = id_valid & ~hazard & ~bus.flush_i;
    issue    = ex_valid & bus.ex_ready_i;
    if_ready = ~id_valid | issue | bus.flush_i;
    load     = bus.if_valid_i & if_ready & ~bus.flush_i;
  end

  // Set after clear, so a same-cycle issue to the retiring register keeps it pending.
  always_comb begin
    set_mask = '0;
    if (issue && writes_rd(opcode) && rd != 5'd0) set_mask[rd] = 1'b1;
    pend_d = (pend_clr | set_mask) & ~32'd1;
  end

  // FSM next-state process
  always_comb begin
    state_d = state_q;
    if (bus.flush_i)
      state_d = S_EMPTY;
    else if (load)
      state_d = src_hazard(bus.if_insn_i[31:0], pend_d) ? S_HAZ : S_RDY;
    else if (issue)
      state_d = S_EMPTY;
    else if (id_valid)
      state_d = src_hazard(id_insn_q[31:0], pend_d) ? S_HAZ : S_RDY;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q     <= '0;
      id_insn_q   <= DWIDTH'(NOP_INSN);
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load) begin
        id_pc_q   <= bus.if_pc_i;
        id_insn_q <= bus.if_insn_i;
      end
      pend_q <= pend_d;
      if (id_valid && hazard && !bus.flush_i && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_id_issue_ctrl;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI1    = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADD2     = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] ADDI3_7  = 32'h0070_0193; // addi x3,x0,7
  localparam logic [31:0] ADDI4_9  = 32'h0090_0213; // addi x4,x0,9
  localparam logic [31:0] ADD6_22  = 32'h0021_0333; // add  x6,x2,x2
  localparam logic [31:0] ADDI5_1  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] ADDI6_X5 = 32'h0002_8313; // addi x6,x5,0
  localparam logic [31:0] ADDI0    = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] ADD7_00  = 32'h0000_03B3; // add  x7,x0,x0

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_issue_ctrl_if bus ();
  id_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  bit          m_valid;
  logic [31:0] m_pc, m_insn;
  bit   [31:0] m_pend;
  int          m_stall;
  int          wq[$];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit uses1(logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction
  function automatic bit uses2(logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction
  function automatic bit writes(logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  endfunction

  function automatic bit m_blocked();
    bit [31:0] p;
    p = m_pend;
    if (bus.wb_valid_i) p[bus.wb_rd_i] = 1'b0;
    return (uses1(m_insn[6:0]) && p[m_insn[19:15]]) || (uses2(m_insn[6:0]) && p[m_insn[24:20]]);
  endfunction

  function automatic bit m_exv();
    return m_valid && !m_blocked() && !bus.flush_i;
  endfunction

  function automatic logic [31:0] imm_of(logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return {{20{i[31]}}, i[31:20]};
      7'h23:               return {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63:               return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:        return {i[31:12], 12'h000};
      7'h6F:               return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [127:0] exp_payload();
    return {m_pc, m_insn, imm_of(m_insn), m_insn[11:7], m_insn[19:15], m_insn[24:20],
            m_insn[6:0], m_insn[14:12], m_insn[31:25]};
  endfunction

  function automatic logic [127:0] dut_payload();
    return {bus.ex_pc_o, bus.ex_insn_o, bus.ex_imm_o, bus.ex_rd_o, bus.ex_rs1_o, bus.ex_rs2_o,
            bus.ex_opcode_o, bus.ex_funct3_o, bus.ex_funct7_o};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0; m_pc = '0; m_insn = NOP; m_pend = '0; m_stall = 0;
    end else begin
      bit iss, blk, rdy;
      bit [31:0] np;
      blk = m_valid && m_blocked();
      iss = m_exv() && bus.ex_ready_i;
      rdy = !m_valid || iss || bus.flush_i;
      np  = m_pend;
      if (bus.wb_valid_i) np[bus.wb_rd_i] = 1'b0;
      if (iss && writes(m_insn[6:0]) && m_insn[11:7] != 5'd0) begin
        np[m_insn[11:7]] = 1'b1;
        wq.push_back(int'(m_insn[11:7]));
      end
      if (blk && !bus.flush_i && m_stall < 65535) m_stall++;
      if (bus.flush_i) m_valid = 1'b0;
      else if (bus.if_valid_i && rdy) begin
        m_valid = 1'b1; m_pc = bus.if_pc_i; m_insn = bus.if_insn_i;
      end else if (iss) m_valid = 1'b0;
      m_pend = np;
    end
  end

  // per-cycle comparison against the model
  always begin
    @(negedge clk); #2;
    if (chk_en && rst) begin
      chk("ex_valid", 128'(bus.ex_valid_o), 128'(m_exv()));
      chk("if_ready", 128'(bus.if_ready_o),
          128'(!m_valid || (m_exv() && bus.ex_ready_i) || bus.flush_i));
      chk("stall_cnt", 128'(bus.stall_cnt_o), 128'(m_stall));
      if (m_exv()) chk("payload", dut_payload(), exp_payload());
    end
  end

  task automatic idle();
    bus.if_valid_i = 1'b0; bus.if_pc_i = '0; bus.if_insn_i = NOP; bus.ex_ready_i = 1'b0;
    bus.wb_valid_i = 1'b0; bus.wb_rd_i = '0; bus.flush_i = 1'b0;
  endtask

  task automatic drv(bit v, logic [31:0] insn, logic [31:0] pc, bit rdy,
                     bit wbv = 1'b0, logic [4:0] wbrd = 5'd0, bit fl = 1'b0);
    @(negedge clk);
    bus.if_valid_i = v; bus.if_insn_i = insn; bus.if_pc_i = pc; bus.ex_ready_i = rdy;
    bus.wb_valid_i = wbv; bus.wb_rd_i = wbrd; bus.flush_i = fl;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, ".ex_valid"}, 128'(bus.ex_valid_o), 128'(0));
    chk({tag, ".if_ready"}, 128'(bus.if_ready_o), 128'(1));
    chk({tag, ".stall"},    128'(bus.stall_cnt_o), 128'(0));
    chk({tag, ".pc"},       128'(bus.ex_pc_o), 128'(0));
    chk({tag, ".insn"},     128'(bus.ex_insn_o), 128'(32'h13));
    chk({tag, ".opcode"},   128'(bus.ex_opcode_o), 128'(7'h13));
    chk({tag, ".rd"},       128'(bus.ex_rd_o), 128'(0));
    chk({tag, ".imm"},      128'(bus.ex_imm_o), 128'(0));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    idle();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; wq.delete(); chk_en = 1'b1;
  endtask

  task automatic rand_cycle();
    logic [31:0] r;
    logic [6:0]  ops[9];
    bit          wbv;
    logic [4:0]  wbrd;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 8)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    wbv = 1'b0; wbrd = '0;
    if (wq.size() > 0 && $urandom_range(0, 9) < 4) begin
      wbv = 1'b1; wbrd = 5'(wq.pop_front());
    end else if ($urandom_range(0, 19) == 0) begin
      wbv = 1'b1; wbrd = 5'($urandom_range(0, 7));
    end
    drv($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 3) != 0, wbv, wbrd,
        $urandom_range(0, 19) == 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 reset_checks("por");
    repeat (2) @(negedge clk);
    rst = 1'b1; chk_en = 1'b1;

    // single instruction, then RAW on x1 resolved by writeback
    drv(1, ADDI1, 32'h100, 1);
    drv(1, ADD2, 32'h104, 1); #2;
    chk("addi.valid", 128'(bus.ex_valid_o), 128'(1));
    chk("addi.rd",    128'(bus.ex_rd_o), 128'(1));
    chk("addi.imm",   128'(bus.ex_imm_o), 128'(5));
    chk("addi.pc",    128'(bus.ex_pc_o), 128'(32'h100));
    drv(0, NOP, 0, 1); #2;
    chk("raw.blocked", 128'(bus.ex_valid_o), 128'(0));
    chk("raw.if_ready", 128'(bus.if_ready_o), 128'(0));
    chk("raw.stall0", 128'(bus.stall_cnt_o), 128'(0));
    drv(0, NOP, 0, 1); #2;
    chk("raw.stall1", 128'(bus.stall_cnt_o), 128'(1));
    drv(0, NOP, 0, 1, 1, 5'd1); #2;
    chk("raw.wb_issue", 128'(bus.ex_valid_o), 128'(1));
    chk("raw.rd", 128'(bus.ex_rd_o), 128'(2));
    chk("raw.stall2", 128'(bus.stall_cnt_o), 128'(2));

    // back-pressure from execute
    drv(1, ADDI3_7, 32'h108, 0); #2;
    chk("bp.empty", 128'(bus.ex_valid_o), 128'(0));
    chk("bp.stall", 128'(bus.stall_cnt_o), 128'(2));
    for (int i = 0; i < 3; i++) begin
      drv(1, ADDI4_9, 32'h10C, 0); #2;
      chk("bp.hold.valid", 128'(bus.ex_valid_o), 128'(1));
      chk("bp.hold.pc", 128'(bus.ex_pc_o), 128'(32'h108));
      chk("bp.hold.imm", 128'(bus.ex_imm_o), 128'(7));
      chk("bp.hold.if_ready", 128'(bus.if_ready_o), 128'(0));
    end
    drv(0, NOP, 0, 1); #2;
    chk("bp.release", 128'(bus.ex_valid_o), 128'(1));
    drv(0, NOP, 0, 1); #2;
    chk("bp.single", 128'(bus.ex_valid_o), 128'(0));

    // flush with a held instruction and a same-cycle fetch beat; x2 stays pending
    drv(1, ADD6_22, 32'h110, 1);
    drv(1, ADDI1, 32'h114, 1, 0, 0, 1); #2;
    chk("flush.valid", 128'(bus.ex_valid_o), 128'(0));
    chk("flush.if_ready", 128'(bus.if_ready_o), 128'(1));
    drv(0, NOP, 0, 1); #2;
    chk("flush.empty", 128'(bus.ex_valid_o), 128'(0));
    drv(1, ADD6_22, 32'h118, 1);
    drv(0, NOP, 0, 1); #2;
    chk("flush.pend_kept", 128'(bus.ex_valid_o), 128'(0));
    drv(0, NOP, 0, 1, 1, 5'd2); #2;
    chk("flush.wb_issue", 128'(bus.ex_valid_o), 128'(1));
    chk("flush.pc", 128'(bus.ex_pc_o), 128'(32'h118));

    // same-cycle set and clear of x5: set wins
    drv(1, ADDI5_1, 32'h11C, 1);
    drv(1, ADDI6_X5, 32'h120, 1, 1, 5'd5); #2;
    chk("sc.issue", 128'(bus.ex_valid_o), 128'(1));
    chk("sc.rd", 128'(bus.ex_rd_o), 128'(5));
    drv(0, NOP, 0, 1); #2;
    chk("sc.pend5", 128'(bus.ex_valid_o), 128'(0));
    drv(0, NOP, 0, 1, 1, 5'd5); #2;
    chk("sc.wb", 128'(bus.ex_valid_o), 128'(1));
    chk("sc.wb.rd", 128'(bus.ex_rd_o), 128'(6));

    // x0 is never pending
    drv(1, ADDI0, 32'h124, 1);
    drv(1, ADD7_00, 32'h128, 1); #2;
    chk("x0.issue", 128'(bus.ex_valid_o), 128'(1));
    drv(0, NOP, 0, 1); #2;
    chk("x0.consumer", 128'(bus.ex_valid_o), 128'(1));
    chk("x0.rd", 128'(bus.ex_rd_o), 128'(7));

    // randomized traffic
    do_reset();
    repeat (3000) rand_cycle();
    for (int i = 0; i < 300 && (wq.size() > 0 || i < 20); i++) begin
      if (wq.size() > 0) drv(0, NOP, 0, 1, 1, 5'(wq.pop_front()));
      else drv(0, NOP, 0, 1);
    end

    // stall counter saturation, then asynchronous reset mid-stall
    drv(1, ADDI1, 32'h180, 1);
    drv(1, ADD2, 32'h184, 1);
    repeat (70000) drv(0, NOP, 0, 1);
    #2;
    chk("sat.stall", 128'(bus.stall_cnt_o), 128'(16'hFFFF));
    chk("sat.valid", 128'(bus.ex_valid_o), 128'(0));
    #1 chk_en = 1'b0; rst = 1'b0;
    #1 reset_checks("async");
    @(negedge clk); rst = 1'b1; wq.delete(); chk_en = 1'b1;
    drv(1, ADD2, 32'h200, 1);
    drv(0, NOP, 0, 1); #2;
    chk("post_rst.issue", 128'(bus.ex_valid_o), 128'(1));
    chk("post_rst.pc", 128'(bus.ex_pc_o), 128'(32'h200));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
